// File: rtl/cos_coprocessor.sv
// Iterative CORDIC cosine responder for the coprocessor opcode; freezes ID/EX while computing.
// Optional quadrant folding to [-pi, pi] is built when COS_RANGE_FOLD_EN is defined.
module cos_coprocessor #(
    parameter int ITER = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] angle,
    input  logic [4:0]  dest_in,
    output logic        freez,
    output logic        busy,
    output logic        wb_en,
    output logic [4:0]  wb_dest,
    output logic [31:0] wb_data,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic signed [31:0] CORDIC_K = 32'sh136E9DB5;
    localparam logic signed [31:0] PI       = 32'sh6487ED51;
    localparam logic signed [31:0] HALF_PI  = 32'sh3243F6A9;
    localparam logic signed [31:0] NEG_PI   = -PI;
    localparam logic signed [31:0] NEG_HALF = -HALF_PI;
    localparam logic [4:0]         LAST_I   = 5'(ITER - 1);

    // round(atan(2^-i) * 2^29); beyond i = 9 the value is exactly 2^(29-i) after rounding
    function automatic logic signed [31:0] atan_lut(input logic [4:0] idx);
        case (idx)
            5'd0:    atan_lut = 32'sd421657428;
            5'd1:    atan_lut = 32'sd248918915;
            5'd2:    atan_lut = 32'sd131521918;
            5'd3:    atan_lut = 32'sd66762579;
            5'd4:    atan_lut = 32'sd33510843;
            5'd5:    atan_lut = 32'sd16771758;
            5'd6:    atan_lut = 32'sd8387925;
            5'd7:    atan_lut = 32'sd4194219;
            5'd8:    atan_lut = 32'sd2097141;
            5'd9:    atan_lut = 32'sd1048575;
            default: atan_lut = $signed(32'd1 << (5'd29 - idx));
        endcase
    endfunction

    state_t             state_q;
    logic signed [31:0] angle_q;
    logic [4:0]         dest_q;
    logic signed [31:0] x_q, y_q, z_q;
    logic [4:0]         i_q;
    logic               neg_q;
    logic               wb_en_q;
    logic               err_q;
    logic [4:0]         wb_dest_q;
    logic [31:0]        wb_data_q;

    logic signed [31:0] x_sh, y_sh, atan_v;
    logic signed [31:0] x_d, y_d, z_d, res_d;
    logic               dir;
    logic signed [31:0] folded;
    logic               fold;
    logic               out_rng;

    always_comb begin
        x_sh   = x_q >>> i_q;
        y_sh   = y_q >>> i_q;
        atan_v = atan_lut(i_q);
        dir    = ~z_q[31];
        x_d    = dir ? (x_q - y_sh) : (x_q + y_sh);
        y_d    = dir ? (y_q + x_sh) : (y_q - x_sh);
        z_d    = dir ? (z_q - atan_v) : (z_q + atan_v);
        res_d  = neg_q ? -x_d : x_d;
    end

`ifdef COS_RANGE_FOLD_EN
    // Reflect |theta| > pi/2 about +-pi/2 so CORDIC only sees its convergent range
    always_comb begin
        out_rng = (angle_q > PI) || (angle_q < NEG_PI);
        fold    = 1'b0;
        folded  = angle_q;
        if (angle_q > HALF_PI) begin
            fold   = 1'b1;
            folded = PI - angle_q;
        end else if (angle_q < NEG_HALF) begin
            fold   = 1'b1;
            folded = NEG_PI - angle_q;
        end
    end
`else
    always_comb begin
        out_rng = (angle_q > HALF_PI) || (angle_q < NEG_HALF);
        fold    = 1'b0;
        folded  = angle_q;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            angle_q   <= '0;
            dest_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            i_q       <= '0;
            neg_q     <= 1'b0;
            wb_en_q   <= 1'b0;
            err_q     <= 1'b0;
            wb_dest_q <= '0;
            wb_data_q <= '0;
        end else if (abort) begin
            state_q <= S_IDLE;
            wb_en_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    wb_en_q <= 1'b0;
                    err_q   <= 1'b0;
                    if (start) begin
                        angle_q <= $signed(angle);
                        dest_q  <= dest_in;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    x_q   <= CORDIC_K;
                    y_q   <= '0;
                    z_q   <= folded;
                    neg_q <= fold;
                    i_q   <= '0;
                    if (out_rng) begin
                        state_q   <= S_DONE;
                        wb_en_q   <= 1'b1;
                        err_q     <= 1'b1;
                        wb_data_q <= '0;
                        wb_dest_q <= dest_q;
                    end else begin
                        state_q <= S_ITER;
                    end
                end
                S_ITER: begin
                    x_q <= x_d;
                    y_q <= y_d;
                    z_q <= z_d;
                    if (i_q == LAST_I) begin
                        state_q   <= S_DONE;
                        wb_en_q   <= 1'b1;
                        err_q     <= 1'b0;
                        wb_data_q <= res_d;
                        wb_dest_q <= dest_q;
                    end else begin
                        i_q <= i_q + 5'd1;
                    end
                end
                default: begin
                    // DONE: the instruction is still in ID/EX, so start is ignored here
                    state_q <= S_IDLE;
                    wb_en_q <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign freez   = ((state_q == S_IDLE) && start && !abort)
                   || (state_q == S_LOAD) || (state_q == S_ITER);
    assign busy    = (state_q != S_IDLE);
    assign wb_en   = wb_en_q;
    assign err     = err_q;
    assign wb_dest = wb_dest_q;
    assign wb_data = wb_data_q;

endmodule

// File: tb/tb_cos_coprocessor.sv
// Directed-vector bench for cos_coprocessor: latency, freeze window, results, abort and reset.
module tb_cos_coprocessor;

    localparam int          ITER = 16;
    localparam int          TOL  = 32'h8000;
    localparam logic [31:0] A_PI3    = 32'h2182A470;
    localparam logic [31:0] A_NPI3   = 32'hDE7D5B90;
    localparam logic [31:0] A_PI     = 32'h6487ED51;
    localparam logic [31:0] A_HALF   = 32'h3243F6A9;
    localparam logic [31:0] A_HALF_P = 32'h3243F6AA;
    localparam logic [31:0] A_2PI3   = 32'h430548E0;

`ifdef COS_RANGE_FOLD_EN
    localparam logic [31:0] EXP_PI_DATA = 32'hE0000000;
    localparam logic [31:0] EXP_2PI3    = 32'hF0000000;
    localparam logic        EXP_OOR_ERR = 1'b0;
    localparam int          EXP_OOR_LAT = 18;
    localparam int          EXP_OOR_FZ  = 18;
`else
    localparam logic [31:0] EXP_PI_DATA = 32'h00000000;
    localparam logic [31:0] EXP_2PI3    = 32'h00000000;
    localparam logic        EXP_OOR_ERR = 1'b1;
    localparam int          EXP_OOR_LAT = 2;
    localparam int          EXP_OOR_FZ  = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] angle = '0;
    logic [4:0]  dest_in = '0;
    logic        freez, busy, wb_en, err;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;

    int n_cmp = 0;
    int n_err = 0;

    cos_coprocessor #(.ITER(ITER)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .angle(angle),
        .dest_in(dest_in), .freez(freez), .busy(busy), .wb_en(wb_en),
        .wb_dest(wb_dest), .wb_data(wb_data), .err(err)
    );

    always #5 clk = ~clk;

    // Drives one start pulse and records what the DUT does over a 40-cycle window
    task automatic do_request(input logic [31:0] a, input logic [4:0] d,
                              output int fz_cnt, output int wb_cyc, output int wb_cnt,
                              output logic [31:0] data, output logic [4:0] dst,
                              output logic e);
        angle = a; dest_in = d; start = 1'b1;
        fz_cnt = 0; wb_cyc = -1; wb_cnt = 0; data = '0; dst = '0; e = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (freez) fz_cnt++;
            if (wb_en) begin
                wb_cnt++;
                if (wb_cyc < 0) begin
                    wb_cyc = k; data = wb_data; dst = wb_dest; e = err;
                end
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic test_reset;
        #12;
        n_cmp++;
        if ({freez, busy, wb_en, err} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags: got %b want 0000", {freez, busy, wb_en, err});
        end
        n_cmp++;
        if ({wb_dest, wb_data} !== 37'd0) begin
            n_err++; $display("FAIL reset_wb: got dest=%0d data=%h want 0/0", wb_dest, wb_data);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        $display("reset released: flags=%b dest=%0d data=%h", {freez, busy, wb_en, err}, wb_dest, wb_data);
    endtask

    task automatic test_cos_zero;
        int fz, cyc, cnt; logic [31:0] dt; logic [4:0] ds; logic e; int diff;
        do_request(32'h0, 5'd5, fz, cyc, cnt, dt, ds, e);
        $display("cos(0): freez=%0d wb_cyc=%0d wb_cnt=%0d dest=%0d data=%h err=%b", fz, cyc, cnt, ds, dt, e);
        n_cmp++; if (fz !== 18) begin n_err++; $display("FAIL zero_freez_cycles: got %0d want 18", fz); end
        n_cmp++; if (cyc !== 18) begin n_err++; $display("FAIL zero_latency: got %0d want 18", cyc); end
        n_cmp++; if (cnt !== 1) begin n_err++; $display("FAIL zero_wb_count: got %0d want 1", cnt); end
        n_cmp++; if (ds !== 5'd5) begin n_err++; $display("FAIL zero_dest: got %0d want 5", ds); end
        n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL zero_err: got %b want 0", e); end
        diff = $signed(dt) - $signed(32'h20000000);
        n_cmp++;
        if (diff > TOL || diff < -TOL) begin
            n_err++; $display("FAIL zero_data: got %h want 20000000 +-8000", dt);
        end
    endtask

    task automatic test_cos_values;
        logic [31:0] ang [4] = '{A_PI3, A_NPI3, A_HALF, A_PI};
        logic [31:0] exp [4] = '{32'h10000000, 32'h10000000, 32'h00000000, EXP_PI_DATA};
        int          lat [4] = '{18, 18, 18, EXP_OOR_LAT};
        logic        eer [4] = '{1'b0, 1'b0, 1'b0, EXP_OOR_ERR};
        int fz, cyc, cnt; logic [31:0] dt; logic [4:0] ds; logic e; int diff;
        for (int t = 0; t < 4; t++) begin
            do_request(ang[t], 5'(10 + t), fz, cyc, cnt, dt, ds, e);
            $display("cos(%h): wb_cyc=%0d dest=%0d data=%h err=%b", ang[t], cyc, ds, dt, e);
            n_cmp++;
            if (cyc !== lat[t]) begin n_err++; $display("FAIL val%0d_latency: got %0d want %0d", t, cyc, lat[t]); end
            n_cmp++;
            if (e !== eer[t]) begin n_err++; $display("FAIL val%0d_err: got %b want %b", t, e, eer[t]); end
            n_cmp++;
            if (ds !== 5'(10 + t)) begin n_err++; $display("FAIL val%0d_dest: got %0d want %0d", t, ds, 10 + t); end
            diff = $signed(dt) - $signed(exp[t]);
            n_cmp++;
            if (diff > TOL || diff < -TOL) begin
                n_err++; $display("FAIL val%0d_data: got %h want %h +-8000", t, dt, exp[t]);
            end
        end
    endtask

    task automatic test_range;
        logic [31:0] ang [3] = '{A_HALF_P, A_2PI3, 32'h80000000};
        logic [31:0] exp [3] = '{32'h00000000, EXP_2PI3, 32'h00000000};
        int          lat [3] = '{EXP_OOR_LAT, EXP_OOR_LAT, 2};
        int          fzw [3] = '{EXP_OOR_FZ, EXP_OOR_FZ, 2};
        logic        eer [3] = '{EXP_OOR_ERR, EXP_OOR_ERR, 1'b1};
        int fz, cyc, cnt; logic [31:0] dt; logic [4:0] ds; logic e; int diff;
        for (int t = 0; t < 3; t++) begin
            do_request(ang[t], 5'd3, fz, cyc, cnt, dt, ds, e);
            $display("range(%h): freez=%0d wb_cyc=%0d data=%h err=%b", ang[t], fz, cyc, dt, e);
            n_cmp++;
            if (cyc !== lat[t]) begin n_err++; $display("FAIL rng%0d_latency: got %0d want %0d", t, cyc, lat[t]); end
            n_cmp++;
            if (fz !== fzw[t]) begin n_err++; $display("FAIL rng%0d_freez: got %0d want %0d", t, fz, fzw[t]); end
            n_cmp++;
            if (e !== eer[t]) begin n_err++; $display("FAIL rng%0d_err: got %b want %b", t, e, eer[t]); end
            diff = $signed(dt) - $signed(exp[t]);
            n_cmp++;
            if (diff > TOL || diff < -TOL) begin
                n_err++; $display("FAIL rng%0d_data: got %h want %h +-8000", t, dt, exp[t]);
            end
        end
    endtask

    task automatic test_abort_idle;
        logic fz_a, busy_a;
        start = 1'b1; abort = 1'b1;
        @(negedge clk); fz_a = freez;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        @(negedge clk); busy_a = busy;
        @(posedge clk); #1;
        $display("abort+start in idle: freez=%b busy_next=%b", fz_a, busy_a);
        n_cmp++; if (fz_a !== 1'b0) begin n_err++; $display("FAIL abort_idle_freez: got %b want 0", fz_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL abort_idle_busy: got %b want 0", busy_a); end
    endtask

    task automatic test_back_to_back_abort;
        int wb_cnt = 0; int wb_first = -1;
        logic fz19 = 1'b0, fz26 = 1'b1, busy26 = 1'b1;
        logic [31:0] data_after = '0; int diff;
        angle = A_PI3; dest_in = 5'd7; start = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (wb_en) begin wb_cnt++; if (wb_first < 0) wb_first = k; end
            if (k == 19) fz19 = freez;
            if (k == 26) begin fz26 = freez; busy26 = busy; end
            if (k == 59) data_after = wb_data;
            @(posedge clk); #1;
            if (k + 1 == 25) begin abort = 1'b1; start = 1'b0; end
            if (k + 1 == 26) abort = 1'b0;
        end
        $display("b2b+abort: wb_cnt=%0d first=%0d freez19=%b freez26=%b busy26=%b data=%h",
                 wb_cnt, wb_first, fz19, fz26, busy26, data_after);
        n_cmp++; if (wb_cnt !== 1) begin n_err++; $display("FAIL b2b_wb_count: got %0d want 1", wb_cnt); end
        n_cmp++; if (wb_first !== 18) begin n_err++; $display("FAIL b2b_first_wb: got %0d want 18", wb_first); end
        n_cmp++; if (fz19 !== 1'b1) begin n_err++; $display("FAIL b2b_accept_freez: got %b want 1", fz19); end
        n_cmp++; if (fz26 !== 1'b0) begin n_err++; $display("FAIL abort_freez: got %b want 0", fz26); end
        n_cmp++; if (busy26 !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy26); end
        diff = $signed(data_after) - $signed(32'h10000000);
        n_cmp++;
        if (diff > TOL || diff < -TOL) begin
            n_err++; $display("FAIL abort_data_kept: got %h want 10000000 +-8000", data_after);
        end
    endtask

    task automatic test_reset_mid;
        int fz, cyc, cnt; logic [31:0] dt; logic [4:0] ds; logic e; int diff;
        int stray = 0;
        angle = 32'h0; dest_in = 5'd9; start = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1; start = 1'b0;
        end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
        #2 rst = 1'b0;
        #1;
        $display("reset mid-iter: flags=%b dest=%0d data=%h", {freez, busy, wb_en, err}, wb_dest, wb_data);
        n_cmp++;
        if ({freez, busy, wb_en, err} !== 4'b0000) begin
            n_err++; $display("FAIL rstmid_flags: got %b want 0000", {freez, busy, wb_en, err});
        end
        n_cmp++;
        if ({wb_dest, wb_data} !== 37'd0) begin
            n_err++; $display("FAIL rstmid_wb: got dest=%0d data=%h want 0/0", wb_dest, wb_data);
        end
        @(negedge clk); @(negedge clk); rst = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (wb_en || busy) stray++;
        end
        @(posedge clk); #1;
        n_cmp++; if (stray !== 0) begin n_err++; $display("FAIL rstmid_stray: got %0d active cycles want 0", stray); end
        do_request(32'h0, 5'd9, fz, cyc, cnt, dt, ds, e);
        $display("after reset cos(0): wb_cyc=%0d dest=%0d data=%h err=%b", cyc, ds, dt, e);
        n_cmp++; if (cyc !== 18) begin n_err++; $display("FAIL rstmid_fresh_latency: got %0d want 18", cyc); end
        n_cmp++; if (ds !== 5'd9) begin n_err++; $display("FAIL rstmid_fresh_dest: got %0d want 9", ds); end
        diff = $signed(dt) - $signed(32'h20000000);
        n_cmp++;
        if (diff > TOL || diff < -TOL) begin
            n_err++; $display("FAIL rstmid_fresh_data: got %h want 20000000 +-8000", dt);
        end
    endtask

    initial begin
        test_reset();
        test_cos_zero();
        test_cos_values();
        test_range();
        test_abort_idle();
        test_back_to_back_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within 500000 time units");
        $fatal(1, "timeout");
    end

endmodule
